// File: rtl/ram_program_loader.sv
// ram_program_loader: streams 16 program bytes into a small RAM while the CPU
// is held, checks them against a trailing checksum byte, then reads the RAM
// back and re-sums it to confirm the image landed correctly.
module ram_program_loader #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       ram_manual_mode,
  output logic       ram_manual_read,
  output logic [3:0] ram_address,
  output logic [7:0] ram_program_switches,
  input  logic [7:0] ram_bus_out,
  output logic       cpu_hold,
  output logic       busy,
  output logic       done,
  output logic [1:0] error_code
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_CSUM   = 2'd2;
  localparam logic [1:0] S_VERIFY = 2'd3;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_CSUM  = 2'b01;
  localparam logic [1:0] E_RDBK  = 2'b10;
  localparam logic [1:0] E_TMOUT = 2'b11;

  localparam logic [31:0] TO_LIM = TIMEOUT_CYCLES;

  logic [1:0]  state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  exp_q, exp_d;
  logic [15:0] timer_q, timer_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;

  logic        active;
  logic        hs;
  logic        to_hit;
  logic [7:0]  vsum;

  assign active = (state_q != S_IDLE);
  assign hs     = byte_ready & byte_valid;
  // This idle edge would bring the timer to TIMEOUT_CYCLES-1.
  assign to_hit = ({16'd0, timer_q} + 32'd2) >= TO_LIM;
  assign vsum   = sum_q + ram_bus_out;

  // Next-state logic; abort overrides everything except reset.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    exp_d   = exp_q;
    timer_d = timer_q;
    done_d  = done_q;
    err_d   = err_q;
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            addr_d  = 4'd0;
            sum_d   = 8'd0;
            timer_d = 16'd0;
            done_d  = 1'b0;
            err_d   = E_NONE;
          end
        end
        S_LOAD: begin
          if (hs) begin
            addr_d  = addr_q + 4'd1;
            sum_d   = sum_q + byte_data;
            timer_d = 16'd0;
            if (addr_q == 4'd15) state_d = S_CSUM;
          end else if (to_hit) begin
            state_d = S_IDLE;
            err_d   = E_TMOUT;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_CSUM: begin
          if (hs) begin
            exp_d   = byte_data;
            timer_d = 16'd0;
            if (sum_q != byte_data) begin
              state_d = S_IDLE;
              err_d   = E_CSUM;
            end else begin
              state_d = S_VERIFY;
              addr_d  = 4'd0;
              sum_d   = 8'd0;
            end
          end else if (to_hit) begin
            state_d = S_IDLE;
            err_d   = E_TMOUT;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        S_VERIFY: begin
          sum_d  = vsum;
          addr_d = addr_q + 4'd1;
          if (addr_q == 4'd15) begin
            state_d = S_IDLE;
            if (vsum == exp_q) done_d = 1'b1;
            else               err_d  = E_RDBK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 4'd0;
      sum_q   <= 8'd0;
      exp_q   <= 8'd0;
      timer_q <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= E_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy                 = active;
  assign cpu_hold             = active;
  assign ram_manual_mode      = active;
  assign byte_ready           = (state_q == S_LOAD) | (state_q == S_CSUM);
  // RAM write happens on the same edge as the byte handshake.
  assign ram_manual_read      = (state_q == S_LOAD) & byte_valid;
  assign ram_address          = active ? addr_q : 4'd0;
  assign ram_program_switches = (state_q == S_LOAD) ? byte_data : 8'd0;
  assign done                 = done_q;
  assign error_code           = err_q;

endmodule
